axi_async_chan_src: RTL
=======================

# axi_async_chan_src

Source (write) half of one channel of the token-based asynchronous AXI link. Accepts a valid/ready stream in the local clock domain, stores beats in a small slot buffer, and publishes a CDC-safe write token plus the buffered beat selected by the far side's read pointer. One instance drives each master-to-slave channel (AW, W, AR) on the master side and each slave-to-master channel (B, R) on the slave side. Channel payload fields are packed into one `data` vector by the instantiating wrapper.

## Interface
- `DATA_WIDTH`, default 64: packed payload width of the channel.
- `BUFFER_WIDTH`, default 4: number of slots N; also the token width; must be ≥2.
- `SYNC_STAGES`, default 2: flops in the read-pointer synchronizer; must be ≥2.

Ports:
- `clk_i`  in  1  local clock; one clock for the whole block, rising edge only.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  upstream beat valid.
- `ready_o`  out  1  upstream ready; slot free.
- `data_i`  in  DATA_WIDTH  upstream payload.
- `writetoken_o`  out  BUFFER_WIDTH  Johnson-coded write count toward the sink domain.
- `readpointer_i`  in  BUFFER_WIDTH  Johnson-coded read count from the sink domain; asynchronous.
- `data_o`  out  DATA_WIDTH  payload of the slot addressed by `readpointer_i`.

## Operation
- **Token code.** Both tokens are N-bit Johnson counters: `next = {cur[N-2:0], ~cur[N-1]}`, so exactly one bit changes per step. Step k toggles bit k mod N. There are 2N states.
- **State.** Write token register `wtok`, binary write index `widx` (0..N-1), N data slots, and a `SYNC_STAGES`-deep synchronizer producing `rsync` from `readpointer_i`.
- **Status.**
  - Empty: `wtok == rsync`.
  - Full: `wtok == ~rsync`.
  - `ready_o = !full`. It is derived from registers only and never depends on `valid_i`.
- **Write.** On `valid_i && ready_o`:
  - `slot[widx] <= data_i`.
  - `wtok` takes one Johnson step.
  - `widx` increments, wrapping from N-1 to 0.
- **No write.** On `valid_i && !ready_o`, nothing changes. Upstream must hold `valid_i` and `data_i` stable until accepted.
- **Output token.** `writetoken_o = wtok`, driven directly from the flop with no logic after it.
- **Output data.** `data_o = slot[ridx]`, combinational from `readpointer_i`.
  - `ridx` is decoded from the raw pointer: popcount(p) if p[N-1]==0, else N−popcount(p).
  - This path is a multicycle/false path. The sink samples only a slot its synchronized `writetoken` marks as written, and the source never overwrites a slot before the matching read toggle returns.
- **Simultaneous events.** A write and a freeing read toggle arriving in the same cycle are independent. The write uses pre-edge `full`. The freed slot becomes usable only once `rsync` reflects it.
- **Reset (`rst_i`=1 at an edge).**
  - `wtok`, `widx` and every synchronizer flop clear to 0.
  - Slots clear to 0.
  - `ready_o` = 1 after reset. `writetoken_o` = 0.
- **Reset mid-operation.** Buffered beats are discarded. The sink side must be reset in the same reset window; a one-sided reset is unsupported.

## Timing
- **Accept.** Handshake at edge e: `writetoken_o` changes just after e, with one toggled bit.
- **Sink visibility.** The sink needs its own synchronizer delay after the token change.
- **Free-slot latency.** A `readpointer_i` change settled before edge e is visible in `rsync` after edge e+SYNC_STAGES−1. `ready_o` rises in that same cycle.
- **Throughput.** One beat per cycle while not full. N slots sustain full rate only if the round trip is ≤ N cycles.
- **Full boundary.** After N accepts with no reads, `ready_o` = 0 from the cycle after the N-th accept.
- **Wrap-around.** The token wraps after 2N steps and `widx` wraps after N. Both wraps are seamless.

## Test plan
- **Reset.** Hold `rst_i` 3 cycles with `valid_i`=1 → no accept, `writetoken_o`=0000, `ready_o`=1 after release.
- **Fill, N=4.** 4 back-to-back beats 0xA0..0xA3 with `readpointer_i` held 0000.
  - `writetoken_o` steps 0001, 0011, 0111, 1111.
  - `ready_o` = 0 after the 4th accept.
  - A 5th beat stalls and is held.
- **Drain/free.** From full, set `readpointer_i`=0001 → `ready_o` returns after SYNC_STAGES edges. Held beat 0xA4 is written to slot 0 and `writetoken_o`=1110.
- **Data select.** With 4 slots written, set `readpointer_i` to 0000, 0001, 0011, 0111 → `data_o` = 0xA0, 0xA1, 0xA2, 0xA3 combinationally.
- **Wrap and concurrency.**
  - Stream 20 beats against a model sink that reads with random 1–5 cycle delays → in-order, loss-free delivery.
  - Every `writetoken_o` change toggles exactly one bit.
  - A same-cycle write plus free-toggle case is covered.
- **Reset mid-stream.** Assert `rst_i` with 2 beats buffered → `writetoken_o`=0 and `ready_o`=1. The next beat lands in slot 0.

Source files
------------

// File: rtl/axi_async_chan_src.sv
// axi_async_chan_src
// Write half of one channel of the token-based asynchronous AXI link.
// Beats accepted from a local valid/ready stream are stored in a small slot
// buffer. The write count goes to the sink domain as a Johnson-coded token,
// and the sink's Johnson-coded read pointer comes back through a
// synchronizer to free slots. The slot the sink addresses is presented
// combinationally on data_o.
module axi_async_chan_src #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BUFFER_WIDTH = 4,   // slot count N, also token width, >= 2
  parameter int unsigned SYNC_STAGES  = 2    // read-pointer synchronizer depth, >= 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [BUFFER_WIDTH-1:0] writetoken_o,
  input  logic [BUFFER_WIDTH-1:0] readpointer_i,
  output logic [DATA_WIDTH-1:0]   data_o
);

  // Binary slot index width and width of a popcount over the token.
  localparam int unsigned IDX_W = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUFFER_WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUFFER_WIDTH - 1);

  // Write-side state.
  logic [BUFFER_WIDTH-1:0] wtok_q, wtok_d;
  logic [IDX_W-1:0]        widx_q, widx_d;

  // Read-pointer synchronizer; the last stage is the only one used by logic.
  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] rsync;

  // Slot storage.
  logic [DATA_WIDTH-1:0]   slot_q [BUFFER_WIDTH];

  // Status and read-side decode.
  logic                    full;
  logic                    write_en;
  logic [CNT_W-1:0]        rd_ones;
  logic [IDX_W-1:0]        ridx;

  // Bring the far-side read pointer into the local clock domain. Johnson
  // coding guarantees at most one bit is in flight, so the captured value is
  // always either the old or the new pointer, never a mix.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's pre-edge value, so this is a real shift register and not a
      // single flop with the intermediate stages collapsed away.
      sync_q[0] <= readpointer_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rsync = sync_q[SYNC_STAGES-1];

  // Tokens equal means empty; write token equal to the inverted read token
  // means the writer is exactly N steps ahead, i.e. every slot is occupied.
  // ready_o depends only on flops so it never combinationally follows valid_i.
  assign full     = (wtok_q == ~rsync);
  assign ready_o  = ~full;
  assign write_en = valid_i & ~full;

  // Next write token and index: one Johnson step and a wrapping increment per accepted beat.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    wtok_d = wtok_q;
    widx_d = widx_q;
    if (write_en) begin
      wtok_d = {wtok_q[BUFFER_WIDTH-2:0], ~wtok_q[BUFFER_WIDTH-1]};
      widx_d = (widx_q == LAST_IDX) ? '0 : widx_q + IDX_W'(1);
    end
  end

  // Write token and index registers; the token flop feeds writetoken_o with no logic after it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wtok_q <= '0;
      widx_q <= '0;
    end else begin
      wtok_q <= wtok_d;
      widx_q <= widx_d;
    end
  end

  assign writetoken_o = wtok_q;

  // Store an accepted beat in the slot addressed by the binary write index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the slots are cleared on reset on purpose, so data_o presents
      // defined zeros rather than stale payload after a reset; this keeps the
      // storage in flops rather than a RAM macro, which suits a buffer this small.
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        slot_q[i] <= '0;
      end
    end else if (write_en) begin
      slot_q[widx_q] <= data_i;
    end
  end

  // Decode the raw read pointer into a slot index. In the first half of the
  // Johnson cycle the popcount is the read count; in the second half (MSB
  // set) the zeros re-fill from the bottom, so the index is N - popcount.
  always_comb begin
    rd_ones = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      rd_ones = rd_ones + CNT_W'(readpointer_i[i]);
    end
    if (readpointer_i[BUFFER_WIDTH-1]) begin
      ridx = IDX_W'(CNT_W'(BUFFER_WIDTH) - rd_ones);
    end else begin
      ridx = IDX_W'(rd_ones);
    end
  end

  // Crossing path: the sink only samples a slot its synchronized write
  // token marks as written, and that slot is not rewritten until the
  // matching read toggle has come back, so the payload is stable whenever
  // it is captured. Constrain as a multicycle/false path.
  assign data_o = slot_q[ridx];

endmodule
